filtered_pulse_gen: RTL and testbench

Transmit side of the filter-protected negative-edge link. On request, it emits a burst of N pulses on a single-bit line, shaped so the companion filtered edge detector counts every one: each pulse is a guaranteed low run, then a guaranteed high run, then a falling edge. The block sits between control logic and the pulse line, and reports progress with a busy/done handshake and a pulses-sent counter.

---
 rtl/filtered_pulse_gen.sv | 111 +++++++++++
 tb/tb_filtered_pulse_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/filtered_pulse_gen.sv
// rtl/filtered_pulse_gen.sv - burst generator of low/high shaped pulses for the filtered edge link
module filtered_pulse_gen #(
    parameter int HIGH_CYCLES = 6,
    parameter int LOW_CYCLES  = 6,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic             abort,
    output logic             q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent
);

    localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int PH_W    = $clog2(MAX_CYC + 1);
    localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_CYCLES - 1);
    localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        TAIL,
        FIN
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            remaining   <= '0;
            q           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pulses_sent <= '0;
                        phase       <= '0;
                        if (num_pulses != '0) begin
                            remaining <= num_pulses;
                            busy      <= 1'b1;
                            state     <= LOW;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                LOW, HIGH, TAIL: begin
                    // Abort wins over any phase completion; a cut-short high run is not counted.
                    if (abort) begin
                        state     <= IDLE;
                        phase     <= '0;
                        remaining <= '0;
                        q         <= 1'b0;
                        busy      <= 1'b0;
                    end else if (state == LOW) begin
                        if (phase == LOW_LAST) begin
                            state <= HIGH;
                            phase <= '0;
                            q     <= 1'b1;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end else if (state == HIGH) begin
                        if (phase == HIGH_LAST) begin
                            phase       <= '0;
                            q           <= 1'b0;
                            remaining   <= remaining - 1'b1;
                            pulses_sent <= pulses_sent + 1'b1;
                            state       <= (remaining == CNT_W'(1)) ? TAIL : LOW;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end else begin
                        if (phase == LOW_LAST) begin
                            state <= FIN;
                            phase <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    phase <= '0;
                    q     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filtered_pulse_gen.sv
// tb/tb_filtered_pulse_gen.sv - scoreboard bench for filtered_pulse_gen
module tb_filtered_pulse_gen;

    localparam int HC = 6;
    localparam int LC = 6;
    localparam int W  = 8;
    localparam int P  = HC + LC;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [W-1:0] num_pulses;
    logic         q;
    logic         busy;
    logic         done;
    logic [W-1:0] pulses_sent;

    filtered_pulse_gen #(.HIGH_CYCLES(HC), .LOW_CYCLES(LC), .CNT_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_pulses(num_pulses),
        .abort(abort),
        .q(q),
        .busy(busy),
        .done(done),
        .pulses_sent(pulses_sent)
    );

    always #5 clk = ~clk;

    // kind: 0 = q rises, 1 = q falls, 2 = done strobe
    typedef struct {
        int kind;
        int at;
        int cnt;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    logic prev_q;
    int   busy_from = 0;
    int   busy_to = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void push_ev(input int kind, input int at, input int cnt);
        ev_t ev;
        ev.kind = kind;
        ev.at   = at;
        ev.cnt  = cnt;
        exp_q.push_back(ev);
    endfunction

    task automatic got_event(input int kind);
        ev_t ev;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            ev = exp_q.pop_front();
            check("event_kind", kind, ev.kind);
            check("event_cycle", cyc, ev.at);
            check("event_count", pulses_sent, ev.cnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("busy", busy, (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
                if (q === 1'b1 && prev_q === 1'b0) got_event(0);
                else if (q === 1'b0 && prev_q === 1'b1) got_event(1);
                else if (q !== prev_q) check("q_known", q, 0);
                if (done === 1'b1) got_event(2);
                prev_q = q;
            end
        end
    end

    // Spec cycle c of a burst whose start is sampled at posedge e is observed at the negedge with cyc = e + c - 1.
    task automatic run_burst(input int n, input int ab, input int rs, input int rs_n, input bit ab0);
        int e;
        int last;
        int nb;
        e = cyc + 1;
        busy_from = e;
        if (n == 0) begin
            push_ev(2, e, 0);
            busy_to = e - 1;
            last = 1;
        end else begin
            nb = n * P + LC;
            if (ab >= 1 && ab <= nb) begin
                for (int k = 0; k < n; k++) begin
                    if (k * P + LC + 1 <= ab) push_ev(0, e + k * P + LC, k);
                    if ((k + 1) * P + 1 <= ab) push_ev(1, e + (k + 1) * P, k + 1);
                end
                if (((ab - 1) % P) >= LC && ab <= n * P) push_ev(1, e + ab, (ab - 1) / P);
                busy_to = e + ab - 1;
                last = ab;
            end else begin
                for (int k = 0; k < n; k++) begin
                    push_ev(0, e + k * P + LC, k);
                    push_ev(1, e + (k + 1) * P, k + 1);
                end
                push_ev(2, e + nb, n);
                busy_to = e + nb - 1;
                last = nb + 1;
            end
        end
        for (int r = 0; r <= last; r++) begin
            start      = (r == 0) || (rs != 0 && r == rs);
            num_pulses = (r == 0) ? W'(n) : W'(rs_n);
            abort      = (ab != 0 && r == ab) || (r == 0 && ab0);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic reset_mid_burst();
        int e;
        e = cyc + 1;
        busy_from = e;
        busy_to   = e + 8;
        push_ev(0, e + 6, 0);
        push_ev(1, e + 9, 0);
        for (int r = 0; r <= 9; r++) begin
            start      = (r == 0);
            num_pulses = W'(5);
            reset      = (r == 9);
            @(negedge clk);
        end
        reset = 1'b0;
        start = 1'b0;
        check("rst_mid_q", q, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_sent", pulses_sent, 0);
        repeat (15) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, ab, rs;
        reset      = 1'b1;
        start      = 1'b1;
        abort      = 1'b0;
        num_pulses = W'(3);
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        start  = 1'b0;
        prev_q = q;
        mon_en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle_q", q, 0);
            check("idle_done", done, 0);
            check("idle_sent", pulses_sent, 0);
        end

        run_burst(3, 0, 0, 0, 1'b0);
        check("burst3_sent", pulses_sent, 3);
        run_burst(0, 0, 0, 0, 1'b0);
        check("zero_sent", pulses_sent, 0);
        run_burst(2, 0, 10, 9, 1'b0);
        check("restart_sent", pulses_sent, 2);
        run_burst(4, 22, 0, 0, 1'b0);
        check("abort_sent", pulses_sent, 1);
        @(negedge clk);
        run_burst(1, 0, 0, 0, 1'b1);
        reset_mid_burst();

        for (int i = 0; i < 30; i++) begin
            n  = $urandom_range(0, 5);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n * P + LC + 1) : 0;
            rs = ($urandom_range(0, 1) == 0) ? $urandom_range(1, n * P + LC + 1) : 0;
            run_burst(n, ab, rs, $urandom_range(0, 9), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("events_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
